bit_stuff_engine: RTL
=====================

Name: bit_stuff_engine

Overview:
- Parametrised bit-stuffing engine for the serial link datapath; sits beside the shift register, in either the encoder (TX) or decoder (RX) path.
- Counts consecutive bits equal to a configurable match value and flags the slot that carries the stuffed bit.
- TX mode: tells the encoder to insert a bit.
- RX mode: tells the decoder to drop the bit, and checks that the dropped bit has the opposite value.

Parameters:
- RUN_LEN, 6: number of consecutive matching bits that triggers a stuff slot. Legal range 2..15.
- MATCH_VAL, 1'b1: bit value counted toward a run. The stuffed bit is ~MATCH_VAL.
- CW, $clog2(RUN_LEN+1): run counter width. Derived; do not override.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- clear, input, 1: synchronous packet-boundary clear (EOP/SYNC).
- mode, input, 1: 0 = TX (stuff), 1 = RX (destuff).
- d_orig, input, 1: current serial bit.
- shift_enable, input, 1: one-cycle strobe; d_orig is valid this cycle.
- bit_stuff, output, 1: registered; high while the next shift slot is a stuff slot.
- stuff_err, output, 1: registered one-cycle pulse; RX stuff slot carried MATCH_VAL.
- run_cnt, output, CW: current run length (0..RUN_LEN).
- err_count, output, 8: saturating error count. Tied to 0 unless STUFF_ERR_CNT_EN is defined.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, run_cnt=0, bit_stuff=0, stuff_err=0, err_count=0.
- Priority: rst > clear > shift_enable.
- clear=1: same effect as reset, except err_count is held. A bit presented with clear in the same cycle is discarded.
- Without shift_enable, all state holds and stuff_err returns to 0.
- FSM states (enum in package):
  - IDLE: run_cnt=0.
  - COUNT: 0 < run_cnt < RUN_LEN.
  - STUFF: run_cnt=RUN_LEN, bit_stuff=1.
- IDLE/COUNT, on shift_enable:
  - d_orig==MATCH_VAL: run_cnt+1. If the new value equals RUN_LEN, go to STUFF (bit_stuff=1 from the next cycle); otherwise go to COUNT.
  - d_orig!=MATCH_VAL: run_cnt=0, go to IDLE.
- STUFF: bit_stuff stays 1 until the next shift_enable (the stuff slot). On that edge: run_cnt=0, state=IDLE, bit_stuff=0.
  - TX: d_orig is ignored in the stuff slot.
  - RX: if d_orig==MATCH_VAL, stuff_err=1 for exactly one cycle. If d_orig==~MATCH_VAL, no error.
- After a stuff slot, the count always restarts from 0. The stuffed bit never counts toward the next run, including an erroneous RX bit.
- Latency: bit_stuff rises 1 clk after the edge that samples the RUN_LEN-th matching bit.
- mode is combinationally sampled only on the stuff-slot edge. Changing mode mid-run is legal and takes effect at that slot.
- Back-to-back shift_enable (every cycle) must work with no lost bits.

Optional Feature:
- STUFF_ERR_CNT_EN defined: err_count increments on every stuff_err pulse, saturates at 8'hFF, is cleared only by rst, and is not cleared by clear.
- Undefined: err_count is constant 0 and no counter flops are synthesised.

Decomposition:
- Package bit_stuff_pkg contains:
  - the state enum (IDLE, COUNT, STUFF);
  - mode constants MODE_TX=1'b0 and MODE_RX=1'b1;
  - the error counter width constant ERR_CW=8.
- One sub-module, sat_err_counter: ERR_CW-bit saturating counter with inc and synchronous rst. It is instantiated only under STUFF_ERR_CNT_EN.
- All FSM and run-counter logic stays in bit_stuff_engine.

Test Plan:
- TX, defaults: shift six 1s on consecutive strobes → bit_stuff=1 one cycle after the 6th. Next strobe → bit_stuff=0, run_cnt=0, stuff_err never asserts.
- RX, defaults: 1,1,1,1,1,1 then 1 in the stuff slot → stuff_err pulses exactly one cycle. With STUFF_ERR_CNT_EN, err_count=1. Repeat 300 times → err_count=255.
- Broken run: 1,1,1,1,1,0,1 → run_cnt sequence 1,2,3,4,5,0,1; bit_stuff stays 0.
- RUN_LEN=3, MATCH_VAL=0, RX: 0,0,0,1 → bit_stuff high before the 4th strobe; no error. Following 0 → run_cnt=1.
- clear and shift_enable together while in STUFF → next cycle state=IDLE, bit_stuff=0, run_cnt=0, no stuff_err; err_count unchanged.
- rst asserted mid-run (run_cnt=4) with shift_enable=1 → all outputs 0 on the next cycle, including err_count.

Source files
------------

// File: rtl/bit_stuff_engine_pkg.sv
// Shared types and constants for the bit-stuffing engine.
package bit_stuff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        STUFF = 2'd2
    } state_t;

    localparam logic MODE_TX = 1'b0;
    localparam logic MODE_RX = 1'b1;

    localparam int unsigned ERR_CW = 8;

endpackage

// File: rtl/bit_stuff_engine_sat_err_counter.sv
// Saturating event counter; holds at all-ones, cleared only by synchronous reset.
module sat_err_counter
    import bit_stuff_pkg::*;
#(
    parameter int unsigned W = ERR_CW
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/bit_stuff_engine.sv
// Bit-stuffing run detector for TX (insert) and RX (drop + check) paths.
// Optional saturating error counter enabled by defining STUFF_ERR_CNT_EN.
module bit_stuff_engine
    import bit_stuff_pkg::*;
#(
    parameter int unsigned RUN_LEN   = 6,
    parameter logic        MATCH_VAL = 1'b1,
    parameter int unsigned CW        = $clog2(RUN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              mode,
    input  logic              d_orig,
    input  logic              shift_enable,
    output logic              bit_stuff,
    output logic              stuff_err,
    output logic [CW-1:0]     run_cnt,
    output logic [ERR_CW-1:0] err_count
);

    localparam logic [CW-1:0] LP_RUN_LEN = CW'(RUN_LEN);

    state_t        r_state;
    logic [CW-1:0] r_run_cnt;
    logic          r_bit_stuff;
    logic          r_stuff_err;

    logic [CW-1:0] w_cnt_next;
    logic          w_match;

    assign w_cnt_next = r_run_cnt + 1'b1;
    assign w_match    = (d_orig == MATCH_VAL);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state     <= IDLE;
            r_run_cnt   <= '0;
            r_bit_stuff <= 1'b0;
            r_stuff_err <= 1'b0;
        end else if (shift_enable) begin
            r_stuff_err <= 1'b0;
            case (r_state)
                IDLE, COUNT: begin
                    if (w_match) begin
                        r_run_cnt <= w_cnt_next;
                        if (w_cnt_next == LP_RUN_LEN) begin
                            r_state     <= STUFF;
                            r_bit_stuff <= 1'b1;
                        end else begin
                            r_state <= COUNT;
                        end
                    end else begin
                        r_run_cnt <= '0;
                        r_state   <= IDLE;
                    end
                end
                STUFF: begin
                    // Stuff slot: the bit here never counts toward the next run.
                    r_run_cnt   <= '0;
                    r_state     <= IDLE;
                    r_bit_stuff <= 1'b0;
                    r_stuff_err <= (mode == MODE_RX) && w_match;
                end
                default: begin
                    r_run_cnt   <= '0;
                    r_state     <= IDLE;
                    r_bit_stuff <= 1'b0;
                end
            endcase
        end else begin
            r_stuff_err <= 1'b0;
        end
    end

    assign bit_stuff = r_bit_stuff;
    assign stuff_err = r_stuff_err;
    assign run_cnt   = r_run_cnt;

`ifdef STUFF_ERR_CNT_EN
    sat_err_counter #(
        .W(ERR_CW)
    ) u_err_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (r_stuff_err),
        .o_count (err_count)
    );
`else
    assign err_count = '0;
`endif

endmodule
